ram_stream_loader: RTL and testbench
====================================

// Module: ram_stream_loader
// PURPOSE
//  Sequencing front end for the RAM_async clause memory, driving its address, write-data and write-enable inputs.
//  Streams nibbles in over a valid/ready port and writes them to consecutive addresses 0..2^A-1.
//  Optionally streams the contents back out, using the memory's combinational read.
//  Sits between the pad-level input deserialiser and the memory; the rest of the solver samples load_done.
// PARAMETERS
//  A   5   address bits; depth = 2^A words
//  D   4   data bits per word
// PORTS
//  clk         in   1   single clock, all state on posedge
//  reset       in   1   synchronous, active-high
//  start_load  in   1   pulse: begin load at address 0
//  start_dump  in   1   pulse: begin read-back at address 0
//  in_valid    in   1   upstream word valid
//  in_ready    out  1   loader accepts word this cycle
//  in_data     in   D   upstream word
//  ram_addr    out  A   memory address
//  ram_din     out  D   memory write data
//  ram_we      out  1   memory write enable
//  ram_dout    in   D   memory read data (combinational from ram_addr)
//  out_valid   out  1   read-back word valid
//  out_ready   in   1   downstream accepts read-back word
//  out_data    out  D   read-back word
//  busy        out  1   state is LOAD or DUMP
//  load_done   out  1   full memory image written since last start_load
// BEHAVIOUR
//  - States: IDLE, LOAD, DUMP. Registered: state, addr (A bits), load_done.
//  - Reset: state=IDLE, addr=0, load_done=0. Reset wins over all other inputs.
//    Mid-operation reset aborts the operation; no write occurs in the reset cycle.
//  - Outputs in reset and IDLE: in_ready=0, ram_we=0, out_valid=0, busy=0, ram_addr=addr.
//  - ram_din=in_data always. out_data=ram_dout in DUMP, else 0.
//  - IDLE: start_load -> LOAD, addr<=0, load_done<=0.
//    start_dump -> DUMP, addr<=0.
//    If both are asserted, start_load wins.
//  - LOAD: in_ready=1, busy=1.
//    ram_we = in_valid (combinational, same cycle); the word is written at addr on that posedge.
//    On an accepted word, addr<=addr+1.
//    Accept at addr=2^A-1 -> IDLE, addr<=0, load_done<=1. No wrap past the last word.
//  - DUMP: out_valid=1, busy=1, ram_we=0; out_data is valid the same cycle addr changes (zero latency).
//    On out_valid&&out_ready, addr<=addr+1. Handshake at addr=2^A-1 -> IDLE, addr<=0.
//    load_done is unchanged by DUMP.
//  - start_load and start_dump are ignored while busy=1.
//  - in_valid is ignored outside LOAD; out_ready is ignored outside DUMP.
//  - Throughput: one word per cycle under continuous valid/ready. Full load = 2^A cycles.
// CONFIGURATION
//  READBACK_EN defined: DUMP state and read-back port are fully functional as described.
//  READBACK_EN undefined: DUMP state is not built; start_dump is ignored; out_valid=0 and out_data=0 constantly.
//    Load path and load_done are unchanged.
// TESTING
//  1 Reset, then start_load; feed 32 words 0..15,0..15 back-to-back
//    -> ram_we high 32 cycles; mem[i]=i%16; load_done=1; busy=0 on the cycle after the last write.
//  2 During LOAD, drop in_valid for 3 cycles after word 5
//    -> addr holds at 6; ram_we=0 for those 3 cycles; final image identical to scenario 1.
//  3 Assert reset at addr=10 mid-load, then restart and load all 0xA
//    -> no write in the reset cycle; load_done=0 until the new load completes; mem all 0xA.
//  4 (READBACK_EN) After scenario 1, start_dump with out_ready toggling 1,0,1,0
//    -> out_data sequence 0..15,0..15; each word held while out_ready=0; 32 handshakes, then IDLE.
//  5 start_load and start_dump in the same IDLE cycle -> LOAD entered.
//    start_dump pulsed during LOAD -> ignored; load completes normally.
//  6 READBACK_EN undefined: start_dump in IDLE -> state stays IDLE; busy=0; out_valid=0 throughout.

Source files
------------

// File: rtl/ram_stream_loader.sv
// Streams D-bit words into a 2^A-deep async RAM and can stream them back out; optional read-back built under READBACK_EN.
// Latency: accepted input word written on the same clock edge; read-back data is combinational from the current address.
// Backpressure: in_ready is high for the whole load; read-back advances only on out_valid && out_ready.
module ram_stream_loader #(
    parameter int A = 5,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_load,
    input  logic         start_dump,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [D-1:0] in_data,
    output logic [A-1:0] ram_addr,
    output logic [D-1:0] ram_din,
    output logic         ram_we,
    input  logic [D-1:0] ram_dout,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [D-1:0] out_data,
    output logic         busy,
    output logic         load_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DUMP = 2'd2
    } state_t;

    localparam logic [A-1:0] LAST_ADDR = '1;

    state_t         state_q, state_d;
    logic [A-1:0]   addr_q, addr_d;
    logic           load_done_q, load_done_d;

`ifndef READBACK_EN
    logic unused_rdback;
    assign unused_rdback = ^{ram_dout, out_ready, start_dump};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            load_done_q <= load_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        load_done_d = load_done_q;
        in_ready    = 1'b0;
        ram_we      = 1'b0;
        out_valid   = 1'b0;
        out_data    = '0;
        busy        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_load) begin
                    state_d     = LOAD;
                    addr_d      = '0;
                    load_done_d = 1'b0;
                end
`ifdef READBACK_EN
                else if (start_dump) begin
                    state_d = DUMP;
                    addr_d  = '0;
                end
`endif
            end
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                ram_we   = in_valid;
                if (in_valid) begin
                    if (addr_q == LAST_ADDR) begin
                        state_d     = IDLE;
                        addr_d      = '0;
                        load_done_d = 1'b1;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
`ifdef READBACK_EN
            DUMP: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_data  = ram_dout;
                if (out_ready) begin
                    if (addr_q == LAST_ADDR) begin
                        state_d = IDLE;
                        addr_d  = '0;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // Reset cycle must not write or handshake, whatever state is being aborted.
        if (reset) begin
            in_ready  = 1'b0;
            ram_we    = 1'b0;
            out_valid = 1'b0;
            out_data  = '0;
            busy      = 1'b0;
        end
    end

    assign ram_addr  = addr_q;
    assign ram_din   = in_data;
    assign load_done = load_done_q;

endmodule

// File: tb/tb_ram_stream_loader.sv
// Randomized bench for ram_stream_loader with an async RAM model and an expected-image scoreboard.
module tb_ram_stream_loader;
    localparam int A = 5;
    localparam int D = 4;
    localparam int N = 32;

    logic         clk = 1'b0;
    logic         reset, start_load, start_dump, in_valid, out_ready;
    logic [D-1:0] in_data, ram_din, ram_dout, out_data;
    logic [A-1:0] ram_addr;
    logic         in_ready, ram_we, out_valid, busy, load_done;

    logic [D-1:0] mem     [N];
    logic [D-1:0] exp_mem [N];
    logic [D-1:0] ld_data [N];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_stream_loader #(.A(A), .D(D)) dut (
        .clk(clk), .reset(reset), .start_load(start_load), .start_dump(start_dump),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .load_done(load_done)
    );

    always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_din;
    assign ram_dout = mem[ram_addr];

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; start_load = 1'b1; start_dump = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        in_data = 4'h5;
        #2;
        checks++;
        if (ram_we !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs we=%0b rdy=%0b busy=%0b ov=%0b od=%0h want all 0", ram_we, in_ready, busy, out_valid, out_data);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0; start_load = 1'b0; start_dump = 1'b0; out_ready = 1'b0;
        #2;
        checks++;
        if (busy !== 1'b0 || ram_we !== 1'b0 || in_ready !== 1'b0 || load_done !== 1'b0 || ram_addr !== '0) begin
            errors++;
            $display("FAIL reset_state busy=%0b we=%0b rdy=%0b done=%0b addr=%0d want 0,0,0,0,0", busy, ram_we, in_ready, load_done, ram_addr);
        end
        in_valid = 1'b0;
    endtask

    // mode 0: continuous, 1: 3-cycle gap before word 6, 2: random gaps, 3: random gaps + start_dump mid-load
    task automatic do_load(input int mode, input bit both);
        int k = 0;
        int cyc = 0;
        int gap = 0;
        bit v;
        @(negedge clk);
        start_load = 1'b1; start_dump = both; in_valid = 1'b0;
        #2;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL load_start_idle busy=%0b want 0", busy);
        end
        @(negedge clk);
        start_load = 1'b0; start_dump = 1'b0;
        while (k < N && cyc < 200) begin
            if (cyc != 0) @(negedge clk);
            case (mode)
                1:       v = !(k == 6 && gap < 3);
                2, 3:    v = ($urandom_range(0, 3) != 0);
                default: v = 1'b1;
            endcase
            if (!v) gap++;
            in_valid   = v;
            in_data    = v ? ld_data[k] : D'($urandom);
            start_dump = (mode == 3 && cyc == 7);
            #2;
            checks++;
            if (in_ready !== 1'b1 || busy !== 1'b1 || ram_we !== v || ram_addr !== A'(k) ||
                load_done !== 1'b0 || ram_din !== in_data || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL load_cycle m%0d c%0d rdy=%0b busy=%0b we=%0b(want %0b) addr=%0d(want %0d) done=%0b ov=%0b",
                         mode, cyc, in_ready, busy, ram_we, v, ram_addr, k, load_done, out_valid);
            end
            if (v) k++;
            cyc++;
        end
        if (k < N) begin
            checks++; errors++;
            $display("FAIL load_timeout words=%0d want %0d", k, N);
        end
        if (mode == 0 || mode == 1) begin
            checks++;
            if (cyc !== N + ((mode == 1) ? 3 : 0)) begin
                errors++;
                $display("FAIL load_cycles got %0d want %0d", cyc, N + ((mode == 1) ? 3 : 0));
            end
        end
        @(negedge clk);
        in_valid = 1'b1; start_dump = 1'b0;
        #2;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || ram_we !== 1'b0 || load_done !== 1'b1 ||
            ram_addr !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL load_end busy=%0b rdy=%0b we=%0b done=%0b addr=%0d ov=%0b want 0,0,0,1,0,0",
                     busy, in_ready, ram_we, load_done, ram_addr, out_valid);
        end
        in_valid = 1'b0;
        for (int i = 0; i < N; i++) exp_mem[i] = ld_data[i];
        for (int i = 0; i < N; i++) begin
            checks++;
            if (mem[i] !== exp_mem[i]) begin
                errors++;
                $display("FAIL load_image m%0d mem[%0d]=%0h want %0h", mode, i, mem[i], exp_mem[i]);
            end
        end
    endtask

    task automatic test_reset_midload();
        @(negedge clk);
        start_load = 1'b1;
        @(negedge clk);
        start_load = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k != 0) @(negedge clk);
            in_valid = 1'b1; in_data = 4'hA;
        end
        @(negedge clk);
        in_valid = 1'b1; in_data = 4'h3; reset = 1'b1;
        #2;
        checks++;
        if (ram_we !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midreset_cycle we=%0b busy=%0b rdy=%0b want 0,0,0", ram_we, busy, in_ready);
        end
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;
        #2;
        checks++;
        if (mem[10] !== exp_mem[10] || busy !== 1'b0 || load_done !== 1'b0 || ram_addr !== '0) begin
            errors++;
            $display("FAIL midreset_after mem10=%0h(want %0h) busy=%0b done=%0b addr=%0d", mem[10], exp_mem[10], busy, load_done, ram_addr);
        end
        for (int i = 0; i < N; i++) ld_data[i] = 4'hA;
        do_load(0, 1'b0);
    endtask

`ifdef READBACK_EN
    task automatic test_dump(input bit rnd);
        int k = 0;
        int cyc = 0;
        bit r;
        @(negedge clk);
        start_dump = 1'b1;
        #2;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL dump_start busy=%0b ov=%0b want 0,0", busy, out_valid);
        end
        @(negedge clk);
        start_dump = 1'b0;
        while (k < N && cyc < 200) begin
            if (cyc != 0) @(negedge clk);
            r = rnd ? 1'($urandom_range(0, 1)) : ((cyc % 2) == 0);
            out_ready = r;
            #2;
            checks++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || ram_we !== 1'b0 || in_ready !== 1'b0 ||
                ram_addr !== A'(k) || out_data !== exp_mem[k]) begin
                errors++;
                $display("FAIL dump_cycle c%0d ov=%0b busy=%0b we=%0b addr=%0d(want %0d) data=%0h(want %0h)",
                         cyc, out_valid, busy, ram_we, ram_addr, k, out_data, exp_mem[k]);
            end
            if (r) k++;
            cyc++;
        end
        if (k < N) begin
            checks++; errors++;
            $display("FAIL dump_timeout words=%0d want %0d", k, N);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #2;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 || load_done !== 1'b1 || ram_addr !== '0) begin
            errors++;
            $display("FAIL dump_end busy=%0b ov=%0b od=%0h done=%0b addr=%0d want 0,0,0,1,0", busy, out_valid, out_data, load_done, ram_addr);
        end
        out_ready = 1'b0;
    endtask
`else
    task automatic test_no_readback();
        @(negedge clk);
        start_dump = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c != 0) @(negedge clk);
            if (c == 1) start_dump = 1'b0;
            #2;
            checks++;
            if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 || ram_addr !== '0 || load_done !== 1'b1) begin
                errors++;
                $display("FAIL nodump c%0d busy=%0b ov=%0b od=%0h addr=%0d done=%0b want 0,0,0,0,1", c, busy, out_valid, out_data, ram_addr, load_done);
            end
        end
        out_ready = 1'b0;
    endtask
`endif

    initial begin
        reset = 1'b1; start_load = 1'b0; start_dump = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        test_reset();
        for (int i = 0; i < N; i++) ld_data[i] = D'(i % 16);
        do_load(0, 1'b0);
        do_load(1, 1'b0);
        test_reset_midload();
        for (int i = 0; i < N; i++) ld_data[i] = D'($urandom);
        do_load(2, 1'b0);
        for (int i = 0; i < N; i++) ld_data[i] = D'(i % 16);
        do_load(3, 1'b1);
`ifdef READBACK_EN
        test_dump(1'b0);
        for (int i = 0; i < N; i++) ld_data[i] = D'($urandom);
        do_load(2, 1'b0);
        test_dump(1'b1);
`else
        test_no_readback();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
